// File: rtl/rhythm_game_sequencer.sv
// Game-flow controller for the LED-matrix rhythm game: countdown, chart playback,
// drain of in-flight notes, and a saturating score accumulator.
module rhythm_game_sequencer #(
    parameter int TICKS_PER_BEAT  = 12_500_000,
    parameter int CHART_LEN       = 64,
    parameter int COUNTDOWN_BEATS = 4,
    parameter int DRAIN_BEATS     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] chart_data,
    input  logic       delete_note,
    input  logic [1:0] score,
    output logic [7:0] chart_addr,
    output logic       shift_en,
    output logic       spawn_R,
    output logic       spawn_B,
    output logic       judge_en,
    output logic [2:0] countdown,
    output logic [2:0] state,
    output logic       game_over,
    output logic [9:0] total_score
);
    localparam int TW = (TICKS_PER_BEAT > 2) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_BEAT - 1);
    localparam logic [7:0]    CHART_LAST = 8'(CHART_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        PLAY  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    drain_cnt;
    logic          running, frozen, beat, start_game;
    logic [1:0]    points;
    logic [10:0]   sum;

    assign running    = (cur == COUNT) || (cur == PLAY) || (cur == DRAIN);
    assign frozen     = pause && ((cur == PLAY) || (cur == DRAIN));
    assign beat       = running && !frozen && (tick_cnt == TICK_LAST);
    assign start_game = ((cur == IDLE) || (cur == DONE)) && start;

    assign state     = cur;
    assign judge_en  = (cur == PLAY) || (cur == DRAIN);
    assign game_over = (cur == DONE);

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE, DONE: if (start) nxt = COUNT;
            COUNT:      if (beat && countdown == 3'd1) nxt = PLAY;
            PLAY:       if (beat && chart_addr == CHART_LAST) nxt = DRAIN;
            DRAIN:      if (beat && drain_cnt == 8'd1) nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        points = 2'd0;
        case (score)
            2'b11:        points = 2'd3;
            2'b10, 2'b01: points = 2'd1;
            default:      points = 2'd0;
        endcase
        sum = {1'b0, total_score} + {9'd0, points};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    // Beat timer restarts from zero on every state change so each phase gets full beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           tick_cnt <= '0;
        else if (nxt != cur || !running)   tick_cnt <= '0;
        else if (beat)                     tick_cnt <= '0;
        else if (!frozen)                  tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countdown  <= 3'd0;
            chart_addr <= 8'd0;
            drain_cnt  <= 8'd0;
        end else if (start_game) begin
            countdown  <= 3'(COUNTDOWN_BEATS);
            chart_addr <= 8'd0;
        end else if (beat) begin
            case (cur)
                COUNT: countdown <= countdown - 3'd1;
                PLAY: begin
                    if (chart_addr == CHART_LAST) drain_cnt <= 8'(DRAIN_BEATS);
                    else                          chart_addr <= chart_addr + 8'd1;
                end
                DRAIN:   drain_cnt <= drain_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    // Spawns use the chart entry at the pre-increment address, sampled on the beat edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_en <= 1'b0;
            spawn_R  <= 1'b0;
            spawn_B  <= 1'b0;
        end else begin
            shift_en <= beat && ((cur == PLAY) || (cur == DRAIN));
            spawn_R  <= beat && (cur == PLAY) && chart_data[1];
            spawn_B  <= beat && (cur == PLAY) && chart_data[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          total_score <= 10'd0;
        else if (start_game)              total_score <= 10'd0;
        else if (judge_en && delete_note) total_score <= sum[10] ? 10'h3FF : sum[9:0];
    end
endmodule

// File: tb/tb_rhythm_game_sequencer.sv
// Scoreboarded bench for rhythm_game_sequencer: expected pulses and scores are queued
// as stimulus is applied and popped when the design produces them.
module tb_rhythm_game_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, pause, delete_note;
    logic [1:0] chart_data, score;
    logic [7:0] chart_addr;
    logic       shift_en, spawn_R, spawn_B, judge_en, game_over;
    logic [2:0] countdown, state;
    logic [9:0] total_score;

    logic [1:0] chart_mem [4];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int   cyc;
        logic r;
        logic b;
    } pulse_t;
    pulse_t pq[$];
    int     sq[$];
    int     model;

    assign chart_data = chart_mem[chart_addr[1:0]];

    rhythm_game_sequencer #(
        .TICKS_PER_BEAT(4), .CHART_LEN(4), .COUNTDOWN_BEATS(2), .DRAIN_BEATS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .chart_data(chart_data),
        .delete_note(delete_note), .score(score), .chart_addr(chart_addr),
        .shift_en(shift_en), .spawn_R(spawn_R), .spawn_B(spawn_B), .judge_en(judge_en),
        .countdown(countdown), .state(state), .game_over(game_over), .total_score(total_score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pts(logic [1:0] s);
        if (s == 2'b11) return 3;
        if (s == 2'b00) return 0;
        return 1;
    endfunction

    function automatic int add_sat(int t, int p);
        return (t + p > 1023) ? 1023 : t + p;
    endfunction

    task automatic test_reset();
        checks++; if (state !== 3'd0)       begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (chart_addr !== 8'd0)  begin failures++; $display("FAIL reset_addr got=%0d exp=0", chart_addr); end
        checks++; if (countdown !== 3'd0)   begin failures++; $display("FAIL reset_countdown got=%0d exp=0", countdown); end
        checks++; if (total_score !== 10'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", total_score); end
        checks++; if ({shift_en, spawn_R, spawn_B, judge_en, game_over} !== 5'b0)
            begin failures++; $display("FAIL reset_flags got=%b exp=00000", {shift_en, spawn_R, spawn_B, judge_en, game_over}); end
    endtask

    task automatic test_normal_run();
        int k;
        pulse_t e;
        @(negedge clk); start = 1'b1; k = cyc + 1;
        pq.push_back('{k+12, 1'b1, 1'b0}); pq.push_back('{k+16, 1'b0, 1'b1});
        pq.push_back('{k+20, 1'b1, 1'b1}); pq.push_back('{k+24, 1'b0, 1'b0});
        pq.push_back('{k+28, 1'b0, 1'b0}); pq.push_back('{k+32, 1'b0, 1'b0});
        @(negedge clk); start = 1'b0;
        checks++; if (state !== 3'd1)     begin failures++; $display("FAIL run_count_entry got=%0d exp=1", state); end
        checks++; if (countdown !== 3'd2) begin failures++; $display("FAIL run_countdown2 got=%0d exp=2", countdown); end
        while (cyc < k + 36) begin
            @(negedge clk);
            if (shift_en) begin
                checks++;
                if (pq.size() == 0) begin failures++; $display("FAIL run_extra_pulse cyc=%0d", cyc - k); end
                else begin
                    e = pq.pop_front();
                    if (cyc !== e.cyc || spawn_R !== e.r || spawn_B !== e.b) begin
                        failures++;
                        $display("FAIL run_pulse got cyc=%0d R=%b B=%b exp cyc=%0d R=%b B=%b", cyc - k, spawn_R, spawn_B, e.cyc - k, e.r, e.b);
                    end
                end
            end else if (spawn_R || spawn_B) begin
                checks++; failures++; $display("FAIL run_spawn_without_shift cyc=%0d", cyc - k);
            end
            if (cyc == k + 4) begin
                checks++; if (countdown !== 3'd1) begin failures++; $display("FAIL run_countdown1 got=%0d exp=1", countdown); end
            end
            if (cyc == k + 7) begin
                checks++; if (state !== 3'd1 || judge_en !== 1'b0) begin failures++; $display("FAIL run_count_len got=%0d/%b exp=1/0", state, judge_en); end
            end
            if (cyc == k + 8) begin
                checks++; if (state !== 3'd2 || countdown !== 3'd0 || chart_addr !== 8'd0 || judge_en !== 1'b1)
                    begin failures++; $display("FAIL run_play_entry got st=%0d cd=%0d a=%0d je=%b exp 2/0/0/1", state, countdown, chart_addr, judge_en); end
            end
            if (cyc == k + 31) begin
                checks++; if (state !== 3'd3 || game_over !== 1'b0) begin failures++; $display("FAIL run_drain got=%0d exp=3", state); end
            end
            if (cyc == k + 32) begin
                checks++; if (state !== 3'd4 || game_over !== 1'b1) begin failures++; $display("FAIL run_done got=%0d/%b exp=4/1", state, game_over); end
            end
        end
        checks++; if (pq.size() != 0) begin failures++; $display("FAIL run_missing_pulses got=%0d exp=0", pq.size()); pq.delete(); end
    endtask

    task automatic test_scoring();
        int k;
        int got;
        logic [1:0] codes [4];
        codes = '{2'b11, 2'b10, 2'b01, 2'b00};
        @(negedge clk); start = 1'b1; k = cyc + 1;
        @(negedge clk); start = 1'b0; model = 0;
        delete_note = 1'b1; score = 2'b11;
        @(negedge clk); delete_note = 1'b0;
        checks++; if (total_score !== 10'd0) begin failures++; $display("FAIL score_in_count got=%0d exp=0", total_score); end
        while (cyc < k + 9) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            score = codes[i]; delete_note = 1'b1;
            model = add_sat(model, pts(codes[i])); sq.push_back(model);
            @(negedge clk); delete_note = 1'b0;
            got = sq.pop_front();
            checks++; if (total_score !== 10'(got)) begin failures++; $display("FAIL score_code%0d got=%0d exp=%0d", i, total_score, got); end
        end
        for (int i = 0; i < 100 && state != 3'd4; i++) @(negedge clk);
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL score_done_timeout got=%0d exp=4", state); end
    endtask

    task automatic test_pause();
        int k;
        int got;
        pulse_t e;
        @(negedge clk); start = 1'b1; k = cyc + 1; model = 0;
        pq.push_back('{k+12, 1'b1, 1'b0}); pq.push_back('{k+26, 1'b0, 1'b1});
        pq.push_back('{k+30, 1'b1, 1'b1}); pq.push_back('{k+34, 1'b0, 1'b0});
        pq.push_back('{k+38, 1'b0, 1'b0}); pq.push_back('{k+42, 1'b0, 1'b0});
        @(negedge clk); start = 1'b0;
        while (cyc < k + 46) begin
            @(negedge clk);
            if (sq.size() > 0) begin
                delete_note = 1'b0; got = sq.pop_front();
                checks++; if (total_score !== 10'(got)) begin failures++; $display("FAIL pause_score got=%0d exp=%0d", total_score, got); end
            end
            if (shift_en) begin
                checks++;
                if (pq.size() == 0) begin failures++; $display("FAIL pause_extra_pulse cyc=%0d", cyc - k); end
                else begin
                    e = pq.pop_front();
                    if (cyc !== e.cyc || spawn_R !== e.r || spawn_B !== e.b) begin
                        failures++;
                        $display("FAIL pause_pulse got cyc=%0d R=%b B=%b exp cyc=%0d R=%b B=%b", cyc - k, spawn_R, spawn_B, e.cyc - k, e.r, e.b);
                    end
                end
            end
            if (cyc >= k + 14 && cyc <= k + 23) begin
                checks++; if (state !== 3'd2 || chart_addr !== 8'd1)
                    begin failures++; $display("FAIL pause_hold got st=%0d a=%0d exp 2/1", state, chart_addr); end
            end
            if (cyc == k + 42) begin
                checks++; if (state !== 3'd4) begin failures++; $display("FAIL pause_done got=%0d exp=4", state); end
            end
            if (cyc == k + 13) pause = 1'b1;
            if (cyc == k + 23) pause = 1'b0;
            if (cyc == k + 15) begin
                delete_note = 1'b1; score = 2'b10;
                model = add_sat(model, pts(2'b10)); sq.push_back(model);
            end
        end
        checks++; if (pq.size() != 0) begin failures++; $display("FAIL pause_missing_pulses got=%0d exp=0", pq.size()); pq.delete(); end
    endtask

    task automatic test_saturation();
        int k;
        int got;
        logic [1:0] s;
        @(negedge clk); start = 1'b1; k = cyc + 1;
        @(negedge clk); start = 1'b0; model = 0;
        while (cyc < k + 9) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 346; i++) begin
            s = (i == 340) ? 2'b01 : 2'b11;
            score = s; delete_note = 1'b1;
            model = add_sat(model, pts(s)); sq.push_back(model);
            @(negedge clk);
            got = sq.pop_front();
            checks++; if (total_score !== 10'(got)) begin failures++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, total_score, got); end
        end
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL sat_frozen_state got=%0d exp=2", state); end
        delete_note = 1'b0; pause = 1'b0;
        for (int i = 0; i < 100 && state != 3'd4; i++) @(negedge clk);
        checks++; if (state !== 3'd4 || total_score !== 10'd1023)
            begin failures++; $display("FAIL sat_done got st=%0d sc=%0d exp 4/1023", state, total_score); end
    endtask

    task automatic test_restart_start_filter();
        int k;
        @(negedge clk); start = 1'b1; k = cyc + 1;
        while (cyc < k + 33) begin
            @(negedge clk);
            if (cyc == k) begin
                checks++; if (state !== 3'd1 || total_score !== 10'd0 || chart_addr !== 8'd0 || countdown !== 3'd2)
                    begin failures++; $display("FAIL restart_entry got st=%0d sc=%0d a=%0d cd=%0d exp 1/0/0/2", state, total_score, chart_addr, countdown); end
            end
            if (cyc >= k + 8 && cyc <= k + 23) begin
                checks++; if (state !== 3'd2) begin failures++; $display("FAIL start_held_play got=%0d exp=2", state); end
            end
            if (cyc == k + 32) begin
                checks++; if (state !== 3'd4) begin failures++; $display("FAIL start_held_done got=%0d exp=4", state); end
            end
            if (cyc == k + 33) begin
                checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_held_restart got=%0d exp=1", state); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!(shift_en && state == 3'd2) && n < 60) begin @(negedge clk); n++; end
        checks++; if (!(shift_en && state == 3'd2)) begin failures++; $display("FAIL rstmid_no_pulse got=%b exp=1", shift_en); end
        #1 rst = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || chart_addr !== 8'd0 || countdown !== 3'd0 || total_score !== 10'd0)
            begin failures++; $display("FAIL rstmid_regs got st=%0d a=%0d cd=%0d sc=%0d exp 0/0/0/0", state, chart_addr, countdown, total_score); end
        checks++; if ({shift_en, spawn_R, spawn_B, judge_en, game_over} !== 5'b0)
            begin failures++; $display("FAIL rstmid_flags got=%b exp=00000", {shift_en, spawn_R, spawn_B, judge_en, game_over}); end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd0 || shift_en !== 1'b0) begin failures++; $display("FAIL rstmid_after got st=%0d se=%b exp 0/0", state, shift_en); end
    endtask

    initial begin
        chart_mem = '{2'b10, 2'b01, 2'b11, 2'b00};
        rst = 1'b1; start = 1'b0; pause = 1'b0; delete_note = 1'b0; score = 2'b00;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_normal_run();
        test_scoring();
        test_pause();
        test_saturation();
        test_restart_start_filter();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
